// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board constants, cell color type and line-clear states
package tetris_pkg;

  localparam int DEF_BOARD_COLS = 10;
  localparam int DEF_BOARD_ROWS = 20;

  typedef logic [2:0] color_t;
  localparam color_t COLOR_EMPTY = 3'd0;

  typedef enum logic [2:0] {
    LC_IDLE,
    LC_READ,
    LC_READ_LAST,
    LC_EVAL,
    LC_COPY,
    LC_FILL,
    LC_DONE
  } lc_state_t;

endpackage

// File: rtl/line_clear_engine_if.sv
// rtl/line_clear_engine_if.sv - start/status handshake and SRAM cell port of the line-clear engine
interface line_clear_engine_if;
  import tetris_pkg::*;

  logic       start;
  logic       busy;
  logic       done;
  logic [5:0] lines_cleared;
  logic [4:0] mem_x;
  logic [5:0] mem_y;
  logic       mem_re;
  logic       mem_we;
  color_t     mem_wdata;
  color_t     mem_rdata;

  // engine side
  modport slave (
    input  start, mem_rdata,
    output busy, done, lines_cleared, mem_x, mem_y, mem_re, mem_we, mem_wdata
  );

  // controller / SRAM side
  modport master (
    output start, mem_rdata,
    input  busy, done, lines_cleared, mem_x, mem_y, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-row cell register file with full-row detect
module line_buffer
  import tetris_pkg::*;
#(
  parameter int N = DEF_BOARD_COLS
) (
  input  logic       clk,
  input  logic       i_we,
  input  logic [4:0] i_widx,
  input  color_t     i_wdata,
  input  logic [4:0] i_ridx,
  output color_t     o_rdata,
  output logic       o_all_nonzero
);

  color_t r_slot [N];

  // load only the addressed slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (i_we && (i_widx == 5'(i))) r_slot[i] <= i_wdata;
    end
  end

  // combinational read; an index past the row reads as empty
  always_comb begin
    o_rdata = COLOR_EMPTY;
    for (int i = 0; i < N; i++) begin
      if (i_ridx == 5'(i)) o_rdata = r_slot[i];
    end
  end

  // a row is full when no slot holds the empty color
  always_comb begin
    o_all_nonzero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (r_slot[i] == COLOR_EMPTY) o_all_nonzero = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - bottom-up full-row removal and board compaction over the SRAM cell port
module line_clear_engine
  import tetris_pkg::*;
#(
  parameter int BOARD_COLS = DEF_BOARD_COLS,
  parameter int BOARD_ROWS = DEF_BOARD_ROWS
) (
  input logic                clk,
  input logic                reset,
  line_clear_engine_if.slave bus
);

  localparam logic [4:0] LAST_COL  = 5'(BOARD_COLS - 1);
  localparam logic [5:0] TOP_ROW   = 6'(BOARD_ROWS - 1);
  localparam logic [5:0] MAX_COUNT = 6'(BOARD_ROWS);

  lc_state_t  r_state;
  logic [4:0] r_col;
  logic [5:0] r_src;
  logic [5:0] r_dst;
  logic       r_dst_valid;
  logic [5:0] r_count;
  logic [5:0] r_lines;
  logic       r_busy;
  logic       r_done;
  logic       r_mem_re;
  logic       r_mem_we;
  logic [4:0] r_mem_x;
  logic [5:0] r_mem_y;
  color_t     r_mem_wdata;

  logic       w_buf_we;
  logic [4:0] w_buf_widx;
  logic [4:0] w_buf_ridx;
  color_t     w_buf_rdata;
  logic       w_full;
  logic [5:0] w_count_inc;

  // read data trails mem_re by one cycle, so each READ cycle stores the previous column
  always_comb begin
    w_buf_we   = 1'b0;
    w_buf_widx = r_col - 5'd1;
    if (r_state == LC_READ && r_col != 5'd0) w_buf_we = 1'b1;
    if (r_state == LC_READ_LAST) begin
      w_buf_we   = 1'b1;
      w_buf_widx = LAST_COL;
    end
  end

  // look one column ahead so the registered write data lines up with mem_x
  assign w_buf_ridx  = (r_state == LC_EVAL) ? 5'd0 : r_col + 5'd1;
  assign w_count_inc = (r_count != MAX_COUNT) ? r_count + 6'd1 : r_count;

  line_buffer #(.N(BOARD_COLS)) u_line_buffer (
    .clk           (clk),
    .i_we          (w_buf_we),
    .i_widx        (w_buf_widx),
    .i_wdata       (bus.mem_rdata),
    .i_ridx        (w_buf_ridx),
    .o_rdata       (w_buf_rdata),
    .o_all_nonzero (w_full)
  );

  // sequencer: row pointers, clear counter and every registered port output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LC_IDLE;
      r_col       <= 5'd0;
      r_src       <= 6'd0;
      r_dst       <= 6'd0;
      r_dst_valid <= 1'b0;
      r_count     <= 6'd0;
      r_lines     <= 6'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_x     <= 5'd0;
      r_mem_y     <= 6'd0;
      r_mem_wdata <= COLOR_EMPTY;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LC_IDLE: begin
          if (bus.start) begin
            r_src       <= TOP_ROW;
            r_dst       <= TOP_ROW;
            r_dst_valid <= 1'b1;
            r_col       <= 5'd0;
            r_count     <= 6'd0;
            r_lines     <= 6'd0;
            r_busy      <= 1'b1;
            r_mem_re    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_x     <= 5'd0;
            r_mem_y     <= TOP_ROW;
            r_state     <= LC_READ;
          end
        end
        LC_READ: begin
          if (r_col == LAST_COL) begin
            r_mem_re <= 1'b0;
            r_state  <= LC_READ_LAST;
          end else begin
            r_col   <= r_col + 5'd1;
            r_mem_x <= r_col + 5'd1;
          end
        end
        LC_READ_LAST: begin
          r_state <= LC_EVAL;
        end
        LC_EVAL: begin
          r_col   <= 5'd0;
          r_mem_x <= 5'd0;
          if (w_full) begin
            r_count <= w_count_inc;
            if (r_src != 6'd0) begin
              r_src    <= r_src - 6'd1;
              r_mem_y  <= r_src - 6'd1;
              r_mem_re <= 1'b1;
              r_state  <= LC_READ;
            end else if (r_dst_valid) begin
              r_mem_y     <= r_dst;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= COLOR_EMPTY;
              r_state     <= LC_FILL;
            end else begin
              r_done  <= 1'b1;
              r_lines <= w_count_inc;
              r_state <= LC_DONE;
            end
          end else if (r_dst != r_src) begin
            r_mem_y     <= r_dst;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_buf_rdata;
            r_state     <= LC_COPY;
          end else if (r_src != 6'd0) begin
            r_src    <= r_src - 6'd1;
            r_dst    <= r_dst - 6'd1;
            r_mem_y  <= r_src - 6'd1;
            r_mem_re <= 1'b1;
            r_state  <= LC_READ;
          end else begin
            // row 0 kept in place: nothing left above to zero
            r_dst_valid <= 1'b0;
            r_done      <= 1'b1;
            r_lines     <= r_count;
            r_state     <= LC_DONE;
          end
        end
        LC_COPY: begin
          if (r_col == LAST_COL) begin
            r_col   <= 5'd0;
            r_mem_x <= 5'd0;
            if (r_src != 6'd0) begin
              r_src    <= r_src - 6'd1;
              r_dst    <= r_dst - 6'd1;
              r_mem_y  <= r_src - 6'd1;
              r_mem_we <= 1'b0;
              r_mem_re <= 1'b1;
              r_state  <= LC_READ;
            end else if (r_dst != 6'd0) begin
              r_dst       <= r_dst - 6'd1;
              r_mem_y     <= r_dst - 6'd1;
              r_mem_wdata <= COLOR_EMPTY;
              r_state     <= LC_FILL;
            end else begin
              r_mem_we    <= 1'b0;
              r_dst_valid <= 1'b0;
              r_done      <= 1'b1;
              r_lines     <= r_count;
              r_state     <= LC_DONE;
            end
          end else begin
            r_col       <= r_col + 5'd1;
            r_mem_x     <= r_col + 5'd1;
            r_mem_wdata <= w_buf_rdata;
          end
        end
        LC_FILL: begin
          if (r_col == LAST_COL) begin
            r_col   <= 5'd0;
            r_mem_x <= 5'd0;
            if (r_dst != 6'd0) begin
              r_dst   <= r_dst - 6'd1;
              r_mem_y <= r_dst - 6'd1;
            end else begin
              r_mem_we    <= 1'b0;
              r_dst_valid <= 1'b0;
              r_done      <= 1'b1;
              r_lines     <= r_count;
              r_state     <= LC_DONE;
            end
          end else begin
            r_col   <= r_col + 5'd1;
            r_mem_x <= r_col + 5'd1;
          end
        end
        LC_DONE: begin
          r_busy  <= 1'b0;
          r_state <= LC_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= LC_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.lines_cleared = r_lines;
  assign bus.mem_x         = r_mem_x;
  assign bus.mem_y         = r_mem_y;
  assign bus.mem_re        = r_mem_re;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - table, random and handshake checks of line_clear_engine against a board model
module tb_line_clear_engine;
  import tetris_pkg::*;

  localparam int COLS = DEF_BOARD_COLS;
  localparam int ROWS = DEF_BOARD_ROWS;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  line_clear_engine_if bus ();

  line_clear_engine #(.BOARD_COLS(COLS), .BOARD_ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM: address {y, x}, read data one cycle after mem_re
  logic [2:0] sram  [2048];
  logic [2:0] stage [2048];
  logic       ld_req;

  function automatic logic [10:0] addr(input int r, input int c);
    return {6'(r), 5'(c)};
  endfunction

  always @(posedge clk) begin
    if (ld_req) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          sram[addr(r, c)] <= stage[addr(r, c)];
    end else if (bus.mem_we) begin
      sram[{bus.mem_y, bus.mem_x}] <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= sram[{bus.mem_y, bus.mem_x}];
  end

  int wr_cnt = 0, both_cnt = 0, busy_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_we) wr_cnt++;
    if (bus.mem_we && bus.mem_re) both_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int brd     [ROWS][COLS];
  int exp_brd [ROWS][COLS];
  int m_lines, m_cycles, m_writes;

  // reference: drop full rows, stack survivors at the bottom, cost from the per-row latency rule
  task automatic model();
    int kept[$];
    int k;
    int copies;
    bit full;
    k = 0;
    copies = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (brd[r][c] == 0) full = 1'b0;
      if (full) k++;
      else begin
        kept.push_back(r);
        if (k > 0) copies++;
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_brd[r][c] = 0;
    for (int i = 0; i < kept.size(); i++)
      for (int c = 0; c < COLS; c++) exp_brd[ROWS - 1 - i][c] = brd[kept[i]][c];
    m_lines  = k;
    m_cycles = (COLS + 2) * ROWS + COLS * copies + COLS * k + 1;
    m_writes = COLS * (copies + k);
  endtask

  task automatic load_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) stage[addr(r, c)] = 3'(brd[r][c]);
    ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
  endtask

  task automatic check_board(input string name);
    int bad, fr, fc, fa, fe;
    bad = 0; fr = 0; fc = 0; fa = 0; fe = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (int'(sram[addr(r, c)]) != exp_brd[r][c]) begin
          if (bad == 0) begin
            fr = r; fc = c; fa = int'(sram[addr(r, c)]); fe = exp_brd[r][c];
          end
          bad++;
        end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s/board: %0d cells differ, first r%0d c%0d got %0d expected %0d",
               name, bad, fr, fc, fa, fe);
    end
  endtask

  task automatic run_pass(input string name, input int e_lines, input int e_cycles, input int e_writes);
    int cyc, w0, b0, x0, d0;
    w0 = wr_cnt; b0 = busy_cnt; x0 = both_cnt; d0 = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({name, "/done_cycle"}, cyc, e_cycles);
    check({name, "/lines_in_done"}, int'(bus.lines_cleared), e_lines);
    tick();
    check({name, "/busy_after"}, int'(bus.busy), 0);
    check({name, "/done_pulses"}, done_cnt - d0, 1);
    check({name, "/busy_cycles"}, busy_cnt - b0, e_cycles);
    check({name, "/writes"}, wr_cnt - w0, e_writes);
    check({name, "/re_we_overlap"}, both_cnt - x0, 0);
    repeat (3) tick();
    check({name, "/lines_held"}, int'(bus.lines_cleared), e_lines);
  endtask

  typedef struct {
    string       name;
    logic [19:0] full_rows;
    int r0, c0, v0, r1, c1, v1, r2, c2, v2;
    int exp_lines, exp_cycles;
    int chk_r, chk_c, chk_v;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input string n, input logic [19:0] f,
                              input int r0, input int c0, input int v0,
                              input int r1, input int c1, input int v1,
                              input int r2, input int c2, input int v2,
                              input int lines, input int cyc,
                              input int cr, input int cc, input int cv);
    vec_t v;
    v.name = n; v.full_rows = f;
    v.r0 = r0; v.c0 = c0; v.v0 = v0;
    v.r1 = r1; v.c1 = c1; v.v1 = v1;
    v.r2 = r2; v.c2 = c2; v.v2 = v2;
    v.exp_lines = lines; v.exp_cycles = cyc;
    v.chk_r = cr; v.chk_c = cc; v.chk_v = cv;
    return v;
  endfunction

  task automatic set_table_board(input int t);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) brd[r][c] = vecs[t].full_rows[r] ? 3 : 0;
    if (vecs[t].r0 >= 0) brd[vecs[t].r0][vecs[t].c0] = vecs[t].v0;
    if (vecs[t].r1 >= 0) brd[vecs[t].r1][vecs[t].c1] = vecs[t].v1;
    if (vecs[t].r2 >= 0) brd[vecs[t].r2][vecs[t].c2] = vecs[t].v2;
  endtask

  task automatic rand_board();
    int kind;
    for (int r = 0; r < ROWS; r++) begin
      kind = int'($urandom_range(0, 3));
      for (int c = 0; c < COLS; c++) begin
        case (kind)
          0:       brd[r][c] = int'($urandom_range(1, 7));
          1:       brd[r][c] = 0;
          default: brd[r][c] = int'($urandom_range(0, 7));
        endcase
      end
    end
  endtask

  initial begin
    int cyc, d0;
    reset = 1'b1;
    bus.start = 1'b0;
    ld_req = 1'b0;

    vecs[0] = mk("empty",     20'h00000, -1,0,0, -1,0,0, -1,0,0, 0, 241, 19, 0, 0);
    vecs[1] = mk("row19",     20'h80000, 18,0,5, -1,0,0, -1,0,0, 1, 441, 19, 0, 5);
    vecs[2] = mk("four_full", 20'hF0000, 15,4,2, -1,0,0, -1,0,0, 4, 441, 19, 4, 2);
    vecs[3] = mk("split",     20'hA0000, 18,0,1, 18,1,2, 16,9,7, 2, 441, 18, 9, 7);
    vecs[4] = mk("row0_only", 20'h00001,  5,3,6, -1,0,0, -1,0,0, 1, 251,  5, 3, 6);
    vecs[5] = mk("all_full",  20'hFFFFF, -1,0,0, -1,0,0, -1,0,0, 20, 441, 0, 0, 0);

    repeat (3) tick();
    check("rst/busy", int'(bus.busy), 0);
    check("rst/done", int'(bus.done), 0);
    check("rst/mem_re", int'(bus.mem_re), 0);
    check("rst/mem_we", int'(bus.mem_we), 0);
    check("rst/lines", int'(bus.lines_cleared), 0);
    check("rst/mem_x", int'(bus.mem_x), 0);
    check("rst/mem_y", int'(bus.mem_y), 0);
    check("rst/mem_wdata", int'(bus.mem_wdata), 0);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      set_table_board(t);
      load_board();
      model();
      run_pass(vecs[t].name, vecs[t].exp_lines, vecs[t].exp_cycles, m_writes);
      check_board(vecs[t].name);
      check({vecs[t].name, "/cell"}, int'(sram[addr(vecs[t].chk_r, vecs[t].chk_c)]), vecs[t].chk_v);
    end

    for (int n = 0; n < 6; n++) begin
      rand_board();
      load_board();
      model();
      run_pass($sformatf("rand%0d", n), m_lines, m_cycles, m_writes);
      check_board($sformatf("rand%0d", n));
    end

    // start held three cycles, then a stray pulse mid-pass: one pass only
    set_table_board(1);
    load_board();
    d0 = done_cnt;
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    repeat (100) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("hs/pass_ended", int'(bus.busy), 0);
    repeat (20) tick();
    check("hs/one_pass", done_cnt - d0, 1);
    check("hs/stays_idle", int'(bus.busy), 0);

    // level start re-triggers right after the IDLE cycle
    set_table_board(0);
    load_board();
    bus.start = 1'b1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("lvl/done_seen", int'(bus.done), 1);
    tick();
    check("lvl/idle_gap", int'(bus.busy), 0);
    tick();
    check("lvl/retrigger", int'(bus.busy), 1);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("lvl/second_end", int'(bus.busy), 0);

    // reset while copying abandons the pass
    set_table_board(1);
    load_board();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.mem_we !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("rstcopy/in_copy", int'(bus.mem_we), 1);
    reset = 1'b1;
    tick();
    check("rstcopy/busy", int'(bus.busy), 0);
    check("rstcopy/done", int'(bus.done), 0);
    check("rstcopy/mem_we", int'(bus.mem_we), 0);
    check("rstcopy/mem_re", int'(bus.mem_re), 0);
    check("rstcopy/lines", int'(bus.lines_cleared), 0);
    reset = 1'b0;
    repeat (2) tick();
    check("rstcopy/no_restart", int'(bus.busy), 0);

    rand_board();
    load_board();
    model();
    run_pass("after_reset", m_lines, m_cycles, m_writes);
    check_board("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
